scanner_link_rx: RTL

SCANNER_LINK_RX -- requirements
Module: scanner_link_rx

---
 rtl/scanner_link_rx.sv | 94 +++++++++
 1 files changed

// File: rtl/scanner_link_rx.sv
// scanner_link_rx: serial command/data receiver with synchronizers, frame decode and timeout abort
module scanner_link_rx #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkIn,
  input  logic       dataIn,
  output logic       cmdValid,
  output logic [7:0] cmdCode,
  output logic       dataValid,
  output logic [7:0] dataByte,
  output logic [1:0] peerLevel,
  output logic       cmdErr,
  output logic       frameErr,
  output logic [7:0] byteCount
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_n;
  logic ck_s1, ck_s2, ck_q, d_s1, d_s2, ck_edge;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] sh, sh_n, gap, gap_n, code_n, byte_n, cnt_n, full;
  logic [1:0] lvl_n;
  logic cmd_v_n, data_v_n, cmd_err_n, frame_err_n;
  assign ck_edge = ck_s2 & ~ck_q;
  assign full = {d_s2, sh[7:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      {ck_s1, ck_s2, ck_q, d_s1, d_s2} <= '0;
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      gap <= '0;
      cmdCode <= '0;
      dataByte <= '0;
      byteCount <= '0;
      peerLevel <= '0;
      {cmdValid, dataValid, cmdErr, frameErr} <= '0;
    end else begin
      {ck_s1, ck_s2, ck_q} <= {clkIn, ck_s1, ck_s2};
      {d_s1, d_s2} <= {dataIn, d_s1};
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      gap <= gap_n;
      cmdCode <= code_n;
      dataByte <= byte_n;
      byteCount <= cnt_n;
      peerLevel <= lvl_n;
      {cmdValid, dataValid, cmdErr, frameErr} <= {cmd_v_n, data_v_n, cmd_err_n, frame_err_n};
    end
  end
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    sh_n = sh;
    gap_n = (state == IDLE) ? 8'd0 : gap + 8'd1;
    code_n = cmdCode;
    byte_n = dataByte;
    cnt_n = byteCount;
    lvl_n = peerLevel;
    {cmd_v_n, data_v_n, cmd_err_n, frame_err_n} = '0;
    if (ck_edge) begin
      gap_n = '0;
      sh_n = full;
      bit_cnt_n = bit_cnt + 3'd1;
      if (state == IDLE) state_n = CMD;
      else if (bit_cnt == 3'd7) begin
        state_n = IDLE;
        if (state == DATA) begin
          byte_n = full;
          data_v_n = 1'b1;
          cnt_n = byteCount + 8'd1;
          lvl_n = 2'd0;
        end else if (full == 8'd7) begin
          cmd_v_n = 1'b1;
          code_n = full;
          state_n = DATA;
        end else if (full inside {8'd2, 8'd3, 8'd4}) begin
          cmd_v_n = 1'b1;
          code_n = full;
          // 2,3,4 map to 1,2,3 through the low two bits
          lvl_n = full[1:0] - 2'd1;
        end else cmd_err_n = 1'b1;
      end
    end else if (state != IDLE && gap == 8'(TIMEOUT)) begin
      frame_err_n = 1'b1;
      state_n = IDLE;
      bit_cnt_n = '0;
      sh_n = '0;
      gap_n = '0;
    end
  end
endmodule
